srl_pipe: RTL and testbench
===========================

// Module: srl_pipe
// PURPOSE
//  3-stage pipelined 32-bit logical right shifter with valid/ready handshake at both ends.
//  Shift amounts per stage: 16/8, then 4/2, then 1. Each stage is a row of 2:1 muxes.
//  Sits between ID/EX operand forwarding (upstream) and the EX/MEM result mux (downstream).
//  Serves SRL/SRLV (and SRA/SRAV when SRA_EN).
// PARAMETERS
//  DATA_W   32  operand width; only 32 supported (elaboration error otherwise)
//  TAG_W    4   width of opaque tag carried alongside data (dest-reg/ROB id)
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        asynchronous, active-high reset
//  flush      in   1        sync pipeline flush (branch mispredict)
//  in_valid   in   1        operand presented
//  in_ready   out  1        pipe accepts operand this cycle
//  in_data    in   DATA_W   value to shift
//  in_shamt   in   5        shift amount 0..31
//  in_tag     in   TAG_W    tag, returned unchanged with result
//  in_arith   in   1        1 = sign-fill (port exists only when SRA_EN defined)
//  out_valid  out  1        result available
//  out_ready  in   1        consumer takes result this cycle
//  out_data   out  DATA_W   shifted result
//  out_tag    out  TAG_W    tag of out_data
// BEHAVIOUR
//  - Reset: all stage valid bits 0 -> out_valid=0; out_data=0, out_tag=0; in_ready=1 after reset
//    deasserts. Reset mid-operation discards all in-flight results.
//  - Handshake: transfer on valid&&ready, both ends. out_valid/out_data/out_tag hold stable
//    while out_valid && !out_ready. in_valid is not required to stay asserted without in_ready.
//  - Stage k register loads when v[k]==0 or stage k+1 (or consumer) takes its content
//    (ready[k] = !v[k] | ready[k+1]). in_ready = ready[0]. No combinational path
//    in_valid->out_valid. out_ready->in_ready is combinational (ripple, acceptable at 3 stages).
//  - Latency: 3 cycles, accept edge to out_valid; throughput 1/cycle with out_ready held high.
//  - Stage 1: shamt[4], shamt[3]. Stage 2: shamt[2], shamt[1]. Stage 3: shamt[0].
//    Remaining shamt bits and the fill bit travel with the payload.
//  - Fill bit: 0 (logical). shamt=0 -> out_data==in_data. shamt=31 -> out_data={31{fill},in[31]}.
//  - Full pipe + out_ready=0: in_ready=0, no data lost or duplicated.
//  - Pipe full, out_ready=1, in_valid=1: accept and retire in the same cycle.
//  - flush=1: all v[k] cleared next edge; in_ready=0 during flush cycle (flush beats
//    simultaneous in_valid); out_valid drops the cycle after flush.
//  - Registers hold their value when not loading (no X propagation into out_data).
// CONFIGURATION
//  SRA_EN defined: in_arith port present; fill = in_arith & in_data[31], captured at stage 1.
//  SRA_EN undefined: no in_arith port; fill tied 0; pure logical shift.
// STRUCTURE
//  Package shift_pkg:
//   - DATA_W, SHAMT_W=5
//   - stage distances {16,8,4,2,1}
//   - typedef struct shift_payload_t {data, shamt_rem, fill, tag}
//  Sub-module shift_stage #(DIST): combinational row of DATA_W 2:1 muxes.
//   - in, sel, fill -> out = sel ? {DIST{fill},in[W-1:DIST]} : in
//   - Instantiated 5 times; srl_pipe adds valid/ready regs and flush.
// TESTING
//  1. in=0xF000_000F, shamt=4, tag=3 -> 3 cycles later out=0x0F00_0000, tag=3.
//  2. 32 back-to-back ops, shamt=0..31, in=0x8000_0001, out_ready=1 -> one result/cycle,
//     in order, each == in>>shamt.
//  3. Pipe full, out_ready=0 for 5 cycles -> in_ready=0, out held; release -> 3 results, in order,
//     no drop/duplicate.
//  4. flush with 2 ops in flight plus in_valid=1 -> in_ready=0 that cycle; no out_valid afterwards.
//  5. rst pulse mid-stream, async (between edges) -> out_valid=0 immediately; next op latency 3.
//  6. SRA_EN: in=0x8000_0000, shamt=31, arith=1 -> 0xFFFF_FFFF; arith=0 -> 0x0000_0001.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types and constants for the srl_pipe shifter.
//   DATA_W / SHAMT_W / TAG_W : operand, shift-amount and tag widths
//   STAGE_DIST               : shift distance of each mux row, first to last
//   shift_payload_t          : per-stage pipeline payload (data, remaining shamt, fill, tag)
// Optional feature macro: SRA_EN (consumed by srl_pipe_if and srl_pipe).
package shift_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned SHAMT_W = 5;
    localparam int unsigned TAG_W   = 4;
    localparam int unsigned NROWS   = 5;

    localparam int unsigned STAGE_DIST [NROWS] = '{16, 8, 4, 2, 1};

    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic [SHAMT_W-1:0] shamt_rem;  // shift bits not yet applied
        logic               fill;       // bit shifted in from the top
        logic [TAG_W-1:0]   tag;
    } shift_payload_t;

endpackage

// File: rtl/srl_pipe_if.sv
// Handshake bundle between the operand source, the shifter pipe and the result consumer.
//   in_valid/in_ready  : operand handshake (in_data, in_shamt, in_tag, in_arith)
//   out_valid/out_ready: result handshake (out_data, out_tag)
//   modport master     : operand source / result consumer side
//   modport slave      : the shifter pipe
// in_arith exists only when SRA_EN is defined.
interface srl_pipe_if
    import shift_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 4
) ();

    logic               in_valid;
    logic               in_ready;
    logic [DATA_W-1:0]  in_data;
    logic [SHAMT_W-1:0] in_shamt;
    logic [TAG_W-1:0]   in_tag;
`ifdef SRA_EN
    logic               in_arith;
`endif
    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  out_data;
    logic [TAG_W-1:0]   out_tag;

    modport master (
        output in_valid, in_data, in_shamt, in_tag,
`ifdef SRA_EN
        output in_arith,
`endif
        output out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    modport slave (
        input  in_valid, in_data, in_shamt, in_tag,
`ifdef SRA_EN
        input  in_arith,
`endif
        input  out_ready,
        output in_ready, out_valid, out_data, out_tag
    );

endinterface

// File: rtl/shift_stage.sv
// One row of W 2:1 muxes: optionally shifts din right by DIST, filling with `fill`.
//   din  : operand
//   sel  : 1 = shift by DIST, 0 = pass through
//   fill : bit replicated into the vacated top positions
//   dout : result
module shift_stage #(
    parameter int unsigned W    = 32,
    parameter int unsigned DIST = 1
) (
    input  logic [W-1:0] din,
    input  logic         sel,
    input  logic         fill,
    output logic [W-1:0] dout
);

    assign dout = sel ? {{DIST{fill}}, din[W-1:DIST]} : din;

endmodule

// File: rtl/srl_pipe.sv
// 3-stage pipelined 32-bit right shifter with valid/ready at both ends.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   flush    : synchronous pipeline flush; blocks acceptance in the flush cycle
//   bus      : srl_pipe_if.slave (operand in, result out)
// Stage 1 applies shamt[4:3], stage 2 shamt[2:1], stage 3 shamt[0].
// Macro SRA_EN: adds in_arith; fill = in_arith & in_data[31]. Otherwise fill is 0.
module srl_pipe
    import shift_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      flush,
    srl_pipe_if.slave bus
);

    localparam int unsigned NSTAGE = 3;

    if (DATA_W != 32) begin : g_data_w_check
        $error("srl_pipe: only DATA_W = 32 is supported");
    end
    if (TAG_W != shift_pkg::TAG_W) begin : g_tag_w_check
        $error("srl_pipe: TAG_W must match shift_pkg::TAG_W");
    end

    shift_payload_t    pl_q [NSTAGE];
    shift_payload_t    pl_d [NSTAGE];
    logic [NSTAGE-1:0] v_q;
    logic [NSTAGE-1:0] ready;
    logic [NSTAGE-1:0] ld;
    logic [DATA_W-1:0] row_out [NROWS];
    logic              fill;

`ifdef SRA_EN
    assign fill = bus.in_arith & bus.in_data[DATA_W-1];
`else
    assign fill = 1'b0;
`endif

    // Stage k can take new content if empty or if everything downstream drains this cycle.
    assign ready[2] = ~v_q[2] | bus.out_ready;
    assign ready[1] = ~v_q[1] | ~v_q[2] | bus.out_ready;
    assign ready[0] = ~v_q[0] | ~v_q[1] | ~v_q[2] | bus.out_ready;

    assign bus.in_ready = ready[0] & ~flush;

    // Payload only moves with a valid item, so idle registers keep their last value.
    assign ld[0] = bus.in_valid & bus.in_ready;
    assign ld[1] = v_q[0] & ready[1] & ~flush;
    assign ld[2] = v_q[1] & ready[2] & ~flush;

    // Stage 1 rows
    shift_stage #(.W(DATA_W), .DIST(STAGE_DIST[0])) u_row0 (
        .din  (bus.in_data),
        .sel  (bus.in_shamt[4]),
        .fill (fill),
        .dout (row_out[0])
    );
    shift_stage #(.W(DATA_W), .DIST(STAGE_DIST[1])) u_row1 (
        .din  (row_out[0]),
        .sel  (bus.in_shamt[3]),
        .fill (fill),
        .dout (row_out[1])
    );

    // Stage 2 rows
    shift_stage #(.W(DATA_W), .DIST(STAGE_DIST[2])) u_row2 (
        .din  (pl_q[0].data),
        .sel  (pl_q[0].shamt_rem[2]),
        .fill (pl_q[0].fill),
        .dout (row_out[2])
    );
    shift_stage #(.W(DATA_W), .DIST(STAGE_DIST[3])) u_row3 (
        .din  (row_out[2]),
        .sel  (pl_q[0].shamt_rem[1]),
        .fill (pl_q[0].fill),
        .dout (row_out[3])
    );

    // Stage 3 row
    shift_stage #(.W(DATA_W), .DIST(STAGE_DIST[4])) u_row4 (
        .din  (pl_q[1].data),
        .sel  (pl_q[1].shamt_rem[0]),
        .fill (pl_q[1].fill),
        .dout (row_out[4])
    );

    always_comb begin
        pl_d[0].data      = row_out[1];
        pl_d[0].shamt_rem = {2'b00, bus.in_shamt[2:0]};
        pl_d[0].fill      = fill;
        pl_d[0].tag       = bus.in_tag;

        pl_d[1]           = pl_q[0];
        pl_d[1].data      = row_out[3];
        pl_d[1].shamt_rem = {4'b0000, pl_q[0].shamt_rem[0]};

        pl_d[2]           = pl_q[1];
        pl_d[2].data      = row_out[4];
        pl_d[2].shamt_rem = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= '0;
            for (int i = 0; i < NSTAGE; i++) begin
                pl_q[i] <= '0;
            end
        end else begin
            if (flush) begin
                v_q <= '0;
            end else begin
                v_q[0] <= ld[0] | (v_q[0] & ~ready[1]);
                v_q[1] <= ld[1] | (v_q[1] & ~ready[2]);
                v_q[2] <= ld[2] | (v_q[2] & ~bus.out_ready);
            end
            for (int i = 0; i < NSTAGE; i++) begin
                if (ld[i]) begin
                    pl_q[i] <= pl_d[i];
                end
            end
        end
    end

    assign bus.out_valid = v_q[2];
    assign bus.out_data  = pl_q[2].data;
    assign bus.out_tag   = pl_q[2].tag;

endmodule

// File: tb/tb_srl_pipe.sv
// Bench for srl_pipe: directed scenarios with literal expectations plus randomized traffic,
// all checked every cycle against a queue-based reference model of the pipe.
module tb_srl_pipe;

`ifdef SRA_EN
    localparam bit SRA = 1'b1;
`else
    localparam bit SRA = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic flush;
    logic tb_arith;

    always #5 clk = ~clk;

    srl_pipe_if #(.DATA_W(32), .TAG_W(4)) bus ();

`ifdef SRA_EN
    assign bus.in_arith = tb_arith;
`endif

    srl_pipe #(.DATA_W(32), .TAG_W(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] data;
        logic [3:0]  tag;
        int unsigned acc_cyc;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc = 0;
    int          n_vec = 0;
    int          n_fail = 0;

    function automatic logic [31:0] ref_shift(logic [31:0] d, logic [4:0] sh, logic arith);
        if (arith) return 32'($signed(d) >>> sh);
        return d >> sh;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
        end
    endtask

    // Reference model: an ordered list of accepted operations. An op reaches the output
    // exactly three edges after acceptance; the pipe refuses input only when it holds
    // three ops and the consumer is stalled, or during a flush.
    always @(negedge clk) begin
        logic exp_valid;
        logic exp_ready;
        exp_t e;
        if (rst) begin
            check("rst out_valid", bus.out_valid, 0);
            check("rst out_data", bus.out_data, 0);
            check("rst out_tag", bus.out_tag, 0);
            q.delete();
        end else begin
            exp_valid = (q.size() > 0) && (cyc - q[0].acc_cyc >= 3);
            exp_ready = !flush && !(q.size() == 3 && !bus.out_ready);
            check("out_valid", bus.out_valid, exp_valid);
            check("in_ready", bus.in_ready, exp_ready);
            if (exp_valid) begin
                check("out_data", bus.out_data, q[0].data);
                check("out_tag", bus.out_tag, q[0].tag);
            end
            if (exp_valid && bus.out_ready) void'(q.pop_front());
            if (flush) begin
                q.delete();
            end else if (bus.in_valid && exp_ready) begin
                e.data    = ref_shift(bus.in_data, bus.in_shamt, SRA & tb_arith);
                e.tag     = bus.in_tag;
                e.acc_cyc = cyc;
                q.push_back(e);
            end
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic v, logic [31:0] d, logic [4:0] sh, logic [3:0] t, logic a,
                         logic ordy, logic fl);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_shamt  = sh;
        bus.in_tag    = t;
        tb_arith      = a;
        bus.out_ready = ordy;
        flush         = fl;
    endtask

    task automatic idle(logic ordy);
        drive(1'b0, 32'h0, 5'd0, 4'h0, 1'b0, ordy, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        idle(1'b1);
        repeat (3) step();
        rst = 1'b0;
        step();

        // 1: single op, latency and literal result
        drive(1'b1, 32'hF000_000F, 5'd4, 4'd3, 1'b0, 1'b1, 1'b0);
        #1 check("ready after reset", bus.in_ready, 1);
        step();
        idle(1'b1);
        step();
        check("t1 not yet valid", bus.out_valid, 0);
        step();
        check("t1 valid", bus.out_valid, 1);
        check("t1 data", bus.out_data, 32'h0F00_0000);
        check("t1 tag", bus.out_tag, 4'd3);
        repeat (3) step();

        // 2: 32 back-to-back ops, shamt 0..31
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 32'h8000_0001, 5'(i), 4'(i), 1'b0, 1'b1, 1'b0);
            step();
        end
        idle(1'b1);
        step();
        check("t2 shamt30 data", bus.out_data, 32'h0000_0002);
        step();
        check("t2 shamt31 data", bus.out_data, 32'h0000_0001);
        check("t2 shamt31 tag", bus.out_tag, 4'hF);
        repeat (3) step();

        // 3: fill the pipe with the consumer stalled, hold, then release
        drive(1'b1, 32'hDEAD_BEEF, 5'd8, 4'd1, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h1234_5678, 5'd12, 4'd2, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'hFFFF_FFFF, 5'd31, 4'd4, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'hCAFE_F00D, 5'd1, 4'd9, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t3 full in_ready", bus.in_ready, 0);
            check("t3 held valid", bus.out_valid, 1);
            check("t3 held data", bus.out_data, 32'h00DE_ADBE);
            step();
        end
        idle(1'b1);
        repeat (6) step();

        // 4: flush with two ops in flight and a new operand offered
        drive(1'b1, 32'h0000_FF00, 5'd4, 4'd5, 1'b0, 1'b1, 1'b0);
        step();
        drive(1'b1, 32'h00FF_0000, 5'd8, 4'd6, 1'b0, 1'b1, 1'b0);
        step();
        drive(1'b1, 32'hFFFF_0000, 5'd16, 4'd7, 1'b0, 1'b1, 1'b1);
        #1 check("t4 flush in_ready", bus.in_ready, 0);
        step();
        idle(1'b1);
        for (int i = 0; i < 5; i++) begin
            check("t4 no out_valid", bus.out_valid, 0);
            step();
        end

        // 5: asynchronous reset between edges, then a fresh op
        drive(1'b1, 32'h0F0F_0F0F, 5'd4, 4'd5, 1'b0, 1'b1, 1'b0);
        step();
        drive(1'b1, 32'hF0F0_F0F0, 5'd4, 4'd6, 1'b0, 1'b1, 1'b0);
        step();
        idle(1'b1);
        step();
        check("t5 pre-reset valid", bus.out_valid, 1);
        #1 rst = 1'b1;
        #1 check("t5 async out_valid", bus.out_valid, 0);
        step();
        rst = 1'b0;
        drive(1'b1, 32'hF000_000F, 5'd4, 4'd6, 1'b0, 1'b1, 1'b0);
        step();
        idle(1'b1);
        step();
        check("t5 not yet valid", bus.out_valid, 0);
        step();
        check("t5 valid", bus.out_valid, 1);
        check("t5 data", bus.out_data, 32'h0F00_0000);
        check("t5 tag", bus.out_tag, 4'd6);
        repeat (3) step();

`ifdef SRA_EN
        // 6: arithmetic vs logical fill
        drive(1'b1, 32'h8000_0000, 5'd31, 4'd7, 1'b1, 1'b1, 1'b0);
        step();
        drive(1'b1, 32'h8000_0000, 5'd31, 4'd8, 1'b0, 1'b1, 1'b0);
        step();
        idle(1'b1);
        step();
        check("t6 sra data", bus.out_data, 32'hFFFF_FFFF);
        step();
        check("t6 srl data", bus.out_data, 32'h0000_0001);
        repeat (3) step();
`endif

        // Randomized traffic with stalls and occasional flushes
        for (int i = 0; i < 2000; i++) begin
            logic [4:0] sh;
            case ($urandom_range(0, 9))
                0:       sh = 5'd0;
                1:       sh = 5'd31;
                default: sh = 5'($urandom_range(0, 31));
            endcase
            drive($urandom_range(0, 99) < 70, $urandom, sh, 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 99) < 60,
                  $urandom_range(0, 99) < 3);
            step();
        end
        idle(1'b1);
        repeat (6) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
